// File: rtl/ibex_pkg.sv
// Shared types and constants for the bf16 divider: operand classification,
// bf16 constants and the divider FSM state encoding.
package ibex_pkg;

    typedef enum logic [2:0] {
        Zero,
        Sub_Norm,
        Norm,
        Inf,
        S_NaN,
        Q_NaN
    } Classif_e;

    localparam logic [15:0]        BF16_QNAN = 16'h7FC0;
    localparam logic signed [9:0]  BF16_BIAS = 10'sd127;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        ROUND,
        DONE
    } bf16_div_state_e;

endpackage

// File: rtl/bf16_lzc.sv
// 8-bit leading-zero counter (combinational); all-zero input yields 8.
module bf16_lzc (
    input  logic [7:0] i_val,
    output logic [3:0] o_cnt
);

    always_comb begin
        o_cnt = 4'd8;
        // Scanning upward leaves the highest set bit as the final winner.
        for (int i = 0; i < 8; i++) begin
            if (i_val[i]) o_cnt = 4'(7 - i);
        end
    end

endmodule

// File: rtl/bf16_div.sv
// Multi-cycle bf16 divider: restoring division (10 quotient bits) followed by
// RNE rounding. Define BF16_DIV_SUBNORM_EN to divide subnormal inputs instead of flushing.
module bf16_div
    import ibex_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [15:0] rs1,
    input  logic [15:0] rs2,
    input  Classif_e    Classif_op_a,
    input  Classif_e    Classif_op_b,
    output logic        valid_o,
    output logic [15:0] rd
);

    bf16_div_state_e    r_state, w_state_nxt;
    logic               w_accept;

    logic [7:0]         w_a_exp, w_b_exp;
    logic [6:0]         w_a_man, w_b_man;
    logic               w_a_sub, w_b_sub;
    logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [7:0]         w_a_sig, w_b_sig;
    logic signed [9:0]  w_a_e, w_b_e, w_e_diff;
    logic               w_sign;
    logic               w_special;
    logic [15:0]        w_spec_res;

    logic [3:0]         r_cnt;
    logic [8:0]         r_rem;
    logic [7:0]         r_dvs;
    logic [9:0]         r_quo;
    logic signed [9:0]  r_exp;
    logic               r_sign;
    logic               r_valid;
    logic [15:0]        r_rd;

    logic               w_q_bit;
    logic [8:0]         w_rem_sub, w_rem_nxt;

    logic [6:0]         w_man;
    logic               w_g, w_r, w_st, w_inc;
    logic [7:0]         w_man_rnd;
    logic signed [9:0]  w_e_norm, w_e_rnd;
    logic [15:0]        w_round_res;

    assign w_a_exp = rs1[14:7];
    assign w_a_man = rs1[6:0];
    assign w_b_exp = rs2[14:7];
    assign w_b_man = rs2[6:0];
    assign w_a_sub = (Classif_op_a == Sub_Norm);
    assign w_b_sub = (Classif_op_b == Sub_Norm);
    assign w_a_nan = (&w_a_exp) & (|w_a_man);
    assign w_b_nan = (&w_b_exp) & (|w_b_man);
    assign w_a_inf = (&w_a_exp) & ~(|w_a_man);
    assign w_b_inf = (&w_b_exp) & ~(|w_b_man);
    assign w_sign  = rs1[15] ^ rs2[15];

`ifdef BF16_DIV_SUBNORM_EN
    logic [3:0] w_a_lzc, w_b_lzc;

    bf16_lzc u_lzc_a (.i_val({1'b0, w_a_man}), .o_cnt(w_a_lzc));
    bf16_lzc u_lzc_b (.i_val({1'b0, w_b_man}), .o_cnt(w_b_lzc));

    // Subnormals are normalised up front so the divider only ever sees a leading 1.
    assign w_a_zero = ~(|w_a_exp) & ~w_a_sub;
    assign w_b_zero = ~(|w_b_exp) & ~w_b_sub;
    assign w_a_sig  = w_a_sub ? ({1'b0, w_a_man} << w_a_lzc) : {1'b1, w_a_man};
    assign w_b_sig  = w_b_sub ? ({1'b0, w_b_man} << w_b_lzc) : {1'b1, w_b_man};
    assign w_a_e    = w_a_sub ? (10'sd1 - $signed({6'b0, w_a_lzc})) : $signed({2'b0, w_a_exp});
    assign w_b_e    = w_b_sub ? (10'sd1 - $signed({6'b0, w_b_lzc})) : $signed({2'b0, w_b_exp});
`else
    assign w_a_zero = ~(|w_a_exp) | w_a_sub;
    assign w_b_zero = ~(|w_b_exp) | w_b_sub;
    assign w_a_sig  = {1'b1, w_a_man};
    assign w_b_sig  = {1'b1, w_b_man};
    assign w_a_e    = $signed({2'b0, w_a_exp});
    assign w_b_e    = $signed({2'b0, w_b_exp});
`endif

    assign w_e_diff = w_a_e - w_b_e + BF16_BIAS;

    always_comb begin
        w_special  = 1'b1;
        w_spec_res = BF16_QNAN;
        if (w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf))
            w_spec_res = BF16_QNAN;
        else if (w_b_zero | w_a_inf)
            w_spec_res = {w_sign, 8'hFF, 7'h00};
        else if (w_a_zero | w_b_inf)
            w_spec_res = {w_sign, 15'h0000};
        else
            w_special = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_special ? DONE : DIVIDE;
                end
            end
            DIVIDE:  if (r_cnt == 4'd9) w_state_nxt = ROUND;
            ROUND:   w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign ready_o = (r_state == IDLE);

    assign w_q_bit   = (r_rem >= {1'b0, r_dvs});
    assign w_rem_sub = w_q_bit ? (r_rem - {1'b0, r_dvs}) : r_rem;
    assign w_rem_nxt = w_rem_sub << 1;

    // Quotient lies in (0.5, 2): a clear MSB means one extra left shift, so the
    // round bit falls off and is covered by sticky.
    always_comb begin
        if (r_quo[9]) begin
            w_man    = r_quo[8:2];
            w_g      = r_quo[1];
            w_r      = r_quo[0];
            w_e_norm = r_exp;
        end else begin
            w_man    = r_quo[7:1];
            w_g      = r_quo[0];
            w_r      = 1'b0;
            w_e_norm = r_exp - 10'sd1;
        end
        w_st      = |r_rem;
        w_inc     = w_g & (w_r | w_st | w_man[0]);
        w_man_rnd = {1'b0, w_man} + {7'b0, w_inc};
        w_e_rnd   = w_e_norm + $signed({9'b0, w_man_rnd[7]});
        if (w_e_rnd >= 10'sd255)
            w_round_res = {r_sign, 8'hFF, 7'h00};
        else if (w_e_rnd <= 10'sd0)
            w_round_res = {r_sign, 15'h0000};
        else
            w_round_res = {r_sign, w_e_rnd[7:0], w_man_rnd[6:0]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt   <= 4'd0;
            r_rem   <= 9'd0;
            r_dvs   <= 8'd0;
            r_quo   <= 10'd0;
            r_exp   <= 10'sd0;
            r_sign  <= 1'b0;
            r_valid <= 1'b0;
            r_rd    <= 16'h0000;
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                r_cnt  <= 4'd0;
                r_rem  <= {1'b0, w_a_sig};
                r_dvs  <= w_b_sig;
                r_quo  <= 10'd0;
                r_exp  <= w_e_diff;
                r_sign <= w_sign;
                if (w_special) begin
                    r_rd    <= w_spec_res;
                    r_valid <= 1'b1;
                end
            end
            if (r_state == DIVIDE) begin
                r_quo <= {r_quo[8:0], w_q_bit};
                r_rem <= w_rem_nxt;
                r_cnt <= r_cnt + 4'd1;
            end
            if (r_state == ROUND) begin
                r_rd    <= w_round_res;
                r_valid <= 1'b1;
            end
        end
    end

    assign valid_o = r_valid;
    assign rd      = r_rd;

endmodule

// File: tb/tb_bf16_div.sv
// Directed-vector bench for bf16_div: latency, special cases, rounding,
// overflow/underflow, reset abort and back-to-back request handling.
module tb_bf16_div;
    import ibex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] rs1, rs2;
    Classif_e    cls_a, cls_b;
    logic        valid_o;
    logic [15:0] rd;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bf16_div dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .rs1          (rs1),
        .rs2          (rs2),
        .Classif_op_a (cls_a),
        .Classif_op_b (cls_b),
        .valid_o      (valid_o),
        .rd           (rd)
    );

    function automatic Classif_e classify(input logic [15:0] x);
        if (x[14:7] == 8'h00)      return (x[6:0] == 7'h0) ? Zero : Sub_Norm;
        else if (x[14:7] == 8'hFF) return (x[6:0] == 7'h0) ? Inf : (x[6] ? Q_NaN : S_NaN);
        else                       return Norm;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b);
        rs1   = a;
        rs2   = b;
        cls_a = classify(a);
        cls_b = classify(b);
    endtask

    // Entered at negedge of T+1; ends at the negedge after the strobe.
    task automatic wait_res(input string tag, input logic [15:0] exp_rd, input int exp_lat);
        int lat;
        chk({tag, " busy"}, {31'b0, ready_o}, 0);
        lat = 1;
        while (!valid_o && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " lat"}, lat, exp_lat);
        chk({tag, " rd"}, {16'b0, rd}, {16'b0, exp_rd});
        @(negedge clk);
        chk({tag, " pulse"}, {30'b0, ready_o, valid_o}, 32'b10);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_rd, input int exp_lat);
        drive(a, b);
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        wait_res(tag, exp_rd, exp_lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected summary");
        $fatal(1);
    end

    initial begin
        int seen;
        int pulses;
        rst     = 1'b1;
        valid_i = 1'b0;
        drive(16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        chk("rst ready", {31'b0, ready_o}, 1);
        chk("rst valid", {31'b0, valid_o}, 0);
        chk("rst rd", {16'b0, rd}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op("1/2",      16'h3F80, 16'h4000, 16'h3F00, 12);
        run_op("1/3",      16'h3F80, 16'h4040, 16'h3EAB, 12);
        run_op("3/1",      16'h4040, 16'h3F80, 16'h4040, 12);
        run_op("-3/2",     16'hC040, 16'h4000, 16'hBFC0, 12);
        run_op("2/0",      16'h4000, 16'h0000, 16'h7F80, 1);
        run_op("-2/0",     16'hC000, 16'h0000, 16'hFF80, 1);
        run_op("0/0",      16'h0000, 16'h0000, 16'h7FC0, 1);
        run_op("inf/inf",  16'h7F80, 16'h7F80, 16'h7FC0, 1);
        run_op("nan/1",    16'h7FC1, 16'h3F80, 16'h7FC0, 1);
        run_op("inf/1",    16'h7F80, 16'h3F80, 16'h7F80, 1);
        run_op("1/inf",    16'h3F80, 16'h7F80, 16'h0000, 1);
        run_op("-0/1",     16'h8000, 16'h3F80, 16'h8000, 1);
        run_op("ovf",      16'h7F7F, 16'h3E80, 16'h7F80, 12);
        run_op("unf",      16'h0080, 16'h4700, 16'h0000, 12);
`ifdef BF16_DIV_SUBNORM_EN
        run_op("sub/sub",  16'h0040, 16'h0040, 16'h3F80, 12);
`else
        run_op("sub/sub",  16'h0040, 16'h0040, 16'h7FC0, 1);
`endif

        // Reset in the middle of DIVIDE must drop the request without a strobe.
        drive(16'h3F80, 16'h4000);
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort ready", {31'b0, ready_o}, 1);
        chk("abort rd", {16'b0, rd}, 0);
        seen = int'(valid_o);
        repeat (20) begin
            @(negedge clk);
            if (valid_o) seen = 1;
        end
        chk("abort no strobe", seen, 0);
        run_op("post rst", 16'h3F80, 16'h4000, 16'h3F00, 12);

        // valid_i held high with changing operands while busy.
        drive(16'h3F80, 16'h4000);
        valid_i = 1'b1;
        pulses  = 0;
        @(negedge clk);
        for (int k = 1; k <= 12; k++) begin
            if (valid_o) pulses++;
            if (k == 12) begin
                chk("hold strobe T+12", {31'b0, valid_o}, 1);
                chk("hold rd", {16'b0, rd}, 32'h3F00);
            end
            if (k == 12) drive(16'h4040, 16'h3F80);
            else         drive(16'h4000 + 16'(k), 16'h3F80);
            @(negedge clk);
        end
        chk("hold pulses", pulses, 1);
        chk("hold T+13", {30'b0, ready_o, valid_o}, 32'b10);
        @(negedge clk);
        valid_i = 1'b0;
        wait_res("hold next", 16'h4040, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
